// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared frame geometry, sink state encoding and magnitude
//                saturation helper for the FFT magnitude sink.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FRAME_LEN = 4096;
    localparam int IDX_W     = 12;
    localparam int MAG_W     = 24;
    localparam int BINS_KEPT = 1024;
    localparam int STORE_W   = 16;
    localparam int ADDR_W    = $clog2(BINS_KEPT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        DROP   = 2'd2,
        REPORT = 2'd3
    } sink_state_e;

    // Clamp a raw magnitude into the stored width; any high bit set means all ones.
    function automatic logic [STORE_W-1:0] sat(input logic [MAG_W-1:0] x);
        if (x[MAG_W-1:STORE_W] == '0) begin
            return x[STORE_W-1:0];
        end
        return '1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_mag_sink_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_mag_sink_if
//  Description : AXI-stream bundle carrying FFT magnitude beats (tdata),
//                bin index (tuser) and frame end (tlast).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_mag_sink_if;
    import fft_pkg::*;

    logic [MAG_W-1:0] tdata;
    logic [IDX_W-1:0] tuser;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tuser, input  tlast, input  tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/fft_mag_sink_peak_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : peak_tracker
//  Description : Running maximum with synchronous clear. Updates only on a
//                strictly greater sample, so the earliest index wins ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module peak_tracker #(
    parameter int VAL_W = 16,
    parameter int IDX_W = 10
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    input  wire logic             update,
    input  wire logic [VAL_W-1:0] val,
    input  wire logic [IDX_W-1:0] idx,
    output logic      [VAL_W-1:0] max_val,
    output logic      [IDX_W-1:0] max_idx
);

    logic [VAL_W-1:0] max_val_q, max_val_d, base_val;
    logic [IDX_W-1:0] max_idx_q, max_idx_d, base_idx;

    // Clear restarts from (0,0); a sample in the same cycle competes against that base.
    always_comb begin
        base_val  = clear ? '0 : max_val_q;
        base_idx  = clear ? '0 : max_idx_q;
        max_val_d = base_val;
        max_idx_d = base_idx;
        if (update && (val > base_val)) begin
            max_val_d = val;
            max_idx_d = idx;
        end
    end

    // Running peak registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_val = max_val_q;
    assign max_idx = max_idx_q;

endmodule
`default_nettype wire

// File: rtl/fft_mag_sink.sv
`default_nettype none
// ============================================================================
//  Module      : fft_mag_sink
//  Description : Receives one FFT magnitude frame, stores the low bins
//                (saturated) to a BRAM write port, tracks the peak bin
//                excluding DC and checks frame framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_mag_sink
    import fft_pkg::*;
#(
    parameter logic [STORE_W-1:0] NOISE_FLOOR = 16'h0040
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              enable,
    fft_mag_sink_if.slave          s,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [STORE_W-1:0]     wr_data,
    output logic                   frame_done,
    output logic [ADDR_W:0]        peak_index,
    output logic [STORE_W-1:0]     peak_mag,
    output logic                   frame_err,
    output logic [7:0]             err_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    sink_state_e          state_q, state_d;
    logic [IDX_W-1:0]     exp_q, exp_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [STORE_W-1:0]   wr_data_q, wr_data_d;
    logic                 frame_done_q, frame_done_d;
    logic [ADDR_W:0]      peak_index_q, peak_index_d;
    logic [STORE_W-1:0]   peak_mag_q, peak_mag_d;
    logic                 frame_err_q, frame_err_d;
    logic [7:0]           err_count_q, err_count_d;

    logic                 beat_acc;
    logic                 start;
    logic                 in_frame;
    logic [IDX_W-1:0]     cur_exp;
    logic [IDX_W-1:0]     idx_hi;
    logic                 in_kept;
    logic [STORE_W-1:0]   mag_sat;
    logic                 trk_clear, trk_update;
    logic [STORE_W-1:0]   trk_val;
    logic [ADDR_W-1:0]    trk_idx;

    // Only REPORT back-pressures the source.
    assign s.tready = (state_q != REPORT);
    assign beat_acc = s.tvalid & s.tready;
    assign idx_hi   = s.tuser >> ADDR_W;
    assign in_kept  = (idx_hi == '0);
    assign mag_sat  = sat(s.tdata);

    peak_tracker #(
        .VAL_W (STORE_W),
        .IDX_W (ADDR_W)
    ) u_peak (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (trk_clear),
        .update  (trk_update),
        .val     (mag_sat),
        .idx     (s.tuser[ADDR_W-1:0]),
        .max_val (trk_val),
        .max_idx (trk_idx)
    );

    // Next-state: frame start detection, index/tlast checking, BRAM write and reporting.
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        peak_index_d = peak_index_q;
        peak_mag_d   = peak_mag_q;
        frame_err_d  = 1'b0;
        err_count_d  = err_count_q;
        trk_clear    = 1'b0;
        trk_update   = 1'b0;
        in_frame     = 1'b0;
        cur_exp      = '0;

        // A tlast beat in DROP closes the bad frame rather than opening a new one.
        start = beat_acc && enable && (s.tuser == '0) &&
                ((state_q == IDLE) || ((state_q == DROP) && !s.tlast));

        case (state_q)
            IDLE: begin
                if (start) in_frame = 1'b1;
            end
            RECV: begin
                if (beat_acc) begin
                    in_frame = 1'b1;
                    cur_exp  = exp_q;
                end
            end
            DROP: begin
                if (start) begin
                    in_frame = 1'b1;
                end else if (beat_acc && s.tlast) begin
                    state_d = IDLE;
                end
            end
            REPORT: begin
                frame_done_d = 1'b1;
                peak_mag_d   = trk_val;
                peak_index_d = (trk_val >= NOISE_FLOOR) ? {1'b0, trk_idx} : '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (in_frame) begin
            trk_clear = start;
            exp_d     = cur_exp + IDX_W'(1);
            if (s.tuser != cur_exp) begin
                // Mismatch wins over tlast; a tlast beat still ends the frame.
                frame_err_d = 1'b1;
                state_d     = s.tlast ? IDLE : DROP;
            end else begin
                if (in_kept) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = s.tuser[ADDR_W-1:0];
                    wr_data_d  = mag_sat;
                    trk_update = (s.tuser != '0);
                end
                if (s.tlast) begin
                    if (cur_exp == LAST_IDX) begin
                        state_d = REPORT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (cur_exp == LAST_IDX) begin
                    frame_err_d = 1'b1;
                    state_d     = DROP;
                end else begin
                    state_d = RECV;
                end
            end
        end

        if (frame_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            peak_index_q <= '0;
            peak_mag_q   <= '0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            peak_index_q <= peak_index_d;
            peak_mag_q   <= peak_mag_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign peak_index = peak_index_q;
    assign peak_mag   = peak_mag_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_mag_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_mag_sink
//  Description : Self-checking bench for fft_mag_sink: randomized frames and
//                tvalid gaps against a behavioural frame/peak model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_mag_sink;
    import fft_pkg::*;

    localparam logic [STORE_W-1:0] NF = 16'h0040;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    fft_mag_sink_if s_if ();

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [STORE_W-1:0] wr_data;
    logic               frame_done;
    logic [ADDR_W:0]    peak_index;
    logic [STORE_W-1:0] peak_mag;
    logic               frame_err;
    logic [7:0]         err_count;

    fft_mag_sink #(.NOISE_FLOOR(NF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .s          (s_if),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .peak_index (peak_index),
        .peak_mag   (peak_mag),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- observation ----------------
    int unsigned        cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [STORE_W-1:0] bram [BINS_KEPT];
    int                 wr_cnt = 0, done_cnt = 0, errp_cnt = 0, tlo_cnt = 0;
    int unsigned        done_cyc = 0, acc_cyc = 0;
    logic [31:0]        done_idx_q[$];
    logic [31:0]        done_mag_q[$];

    always @(negedge clk) begin
        if (wr_en) begin
            bram[wr_addr] = wr_data;
            wr_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_idx_q.push_back(32'(peak_index));
            done_mag_q.push_back(32'(peak_mag));
        end
        if (frame_err) errp_cnt++;
        if (rst_n && !s_if.tready) tlo_cnt++;
    end

    // ---------------- reference model ----------------
    logic [MAG_W-1:0] mag [FRAME_LEN];
    logic [31:0]      last_idx = 0, last_mag = 0;
    int               exp_errs = 0;
    int               wr0, done0, err0, tlo0;

    function automatic logic [STORE_W-1:0] ref_sat(input logic [MAG_W-1:0] x);
        if (int'(x) > 65535) return 16'hFFFF;
        return x[STORE_W-1:0];
    endfunction

    task automatic ref_peak(output logic [31:0] eidx, output logic [31:0] emag);
        int best = 0, bi = 0;
        for (int i = 1; i < BINS_KEPT; i++) begin
            if (int'(ref_sat(mag[i])) > best) begin
                best = int'(ref_sat(mag[i]));
                bi   = i;
            end
        end
        emag = 32'(best);
        eidx = (best >= int'(NF)) ? 32'(bi) : 32'd0;
    endtask

    task automatic fill_const(input logic [MAG_W-1:0] v);
        for (int i = 0; i < FRAME_LEN; i++) mag[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < FRAME_LEN; i++) mag[i] = MAG_W'($urandom) >> $urandom_range(23);
    endtask

    task automatic snap();
        wr0 = wr_cnt; done0 = done_cnt; err0 = errp_cnt; tlo0 = tlo_cnt;
    endtask

    task automatic settle();
        s_if.tvalid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_bram(input string tag);
        int nmis = 0;
        for (int i = 0; i < BINS_KEPT; i++) if (bram[i] !== ref_sat(mag[i])) nmis++;
        check_eq(tag, nmis, 0);
    endtask

    task automatic check_report(input string tag, input logic [31:0] eidx, input logic [31:0] emag);
        check_eq({tag, "_avail"}, 32'(done_idx_q.size() > 0), 1);
        if (done_idx_q.size() > 0) begin
            check_eq({tag, "_idx"}, done_idx_q.pop_front(), eidx);
            check_eq({tag, "_mag"}, done_mag_q.pop_front(), emag);
        end
        last_idx = eidx;
        last_mag = emag;
    endtask

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic drive_beat(input logic [MAG_W-1:0] d, input int u, input bit l, input int gap_pct);
        int waitc = 0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            s_if.tvalid = 1'b0;
            @(negedge clk);
        end
        s_if.tdata  = d;
        s_if.tuser  = u[IDX_W-1:0];
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        while (!s_if.tready) begin
            @(negedge clk);
            waitc++;
            if (waitc > 50) begin
                check_eq("tready_timeout", waitc, 0);
                break;
            end
        end
        acc_cyc = cyc;
        @(negedge clk);
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n_beats, input int last_at, input int gap_pct);
        for (int i = 0; i < n_beats; i++) drive_beat(mag[i], i, (i == last_at), (i == 0) ? 0 : gap_pct);
    endtask

    task automatic clean_frame(input string tag, input int gap_pct);
        logic [31:0] ei, em;
        ref_peak(ei, em);
        snap();
        send_frame(FRAME_LEN, FRAME_LEN - 1, gap_pct);
        settle();
        check_eq({tag, "_done"}, done_cnt - done0, 1);
        check_eq({tag, "_writes"}, wr_cnt - wr0, BINS_KEPT);
        check_report(tag, ei, em);
        check_bram({tag, "_bram"});
        check_eq({tag, "_errcnt"}, 32'(err_count), exp_errs);
    endtask

    initial begin
        logic [31:0] ei, em;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_wr_en", 32'(wr_en), 0);
        check_eq("rst_done", 32'(frame_done), 0);
        check_eq("rst_err", 32'(frame_err), 0);
        check_eq("rst_errcnt", 32'(err_count), 0);
        check_eq("rst_pidx", 32'(peak_index), 0);
        check_eq("rst_pmag", 32'(peak_mag), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame, continuous tvalid, with latency checks.
        fill_const(24'h10); mag[100] = 24'h1234;
        snap();
        send_frame(FRAME_LEN, FRAME_LEN - 1, 0);
        settle();
        check_eq("f1_tready_low", tlo_cnt - tlo0, 1);
        check_eq("f1_done_lat", done_cyc - acc_cyc, 2);
        check_eq("f1_done", done_cnt - done0, 1);
        check_eq("f1_writes", wr_cnt - wr0, BINS_KEPT);
        check_report("f1", 100, 32'h1234);
        check_bram("f1_bram");
        check_eq("f1_errcnt", 32'(err_count), 0);

        // Same frame with gaps, then the tie frame presented during REPORT.
        snap();
        send_frame(FRAME_LEN, FRAME_LEN - 1, 30);
        for (int i = 0; i < FRAME_LEN; i++)
            mag[i] = (i < BINS_KEPT) ? MAG_W'($urandom_range(16'h07FF)) : MAG_W'($urandom);
        mag[200] = 24'h0800; mag[300] = 24'h0800; mag[50] = 24'h30000;
        send_frame(FRAME_LEN, FRAME_LEN - 1, 0);
        settle();
        check_eq("f23_done", done_cnt - done0, 2);
        check_eq("f23_tready_low", tlo_cnt - tlo0, 2);
        check_eq("f23_writes", wr_cnt - wr0, 2 * BINS_KEPT);
        check_report("f2", 100, 32'h1234);
        check_report("f3", 50, 32'hFFFF);
        check_eq("f3_bram50", 32'(bram[50]), 32'hFFFF);
        check_bram("f3_bram");

        // Everything below the noise floor; DC bin is huge but excluded.
        fill_const(24'h20); mag[0] = 24'hFFFF;
        ref_peak(ei, em);
        check_eq("f4_model_idx", ei, 0);
        clean_frame("f4", 0);

        // Random magnitudes with random tvalid gaps.
        fill_rand();
        clean_frame("f5", 30);

        // Frame start attempts while disabled are discarded silently.
        enable = 1'b0;
        snap();
        for (int i = 0; i < 4; i++) drive_beat(24'h5555, i, (i == 3), 0);
        settle();
        enable = 1'b1;
        check_eq("dis_writes", wr_cnt - wr0, 0);
        check_eq("dis_err", errp_cnt - err0, 0);
        check_eq("dis_done", done_cnt - done0, 0);

        // Early tlast at index 2000: error, no report, written bins remain.
        fill_rand();
        snap();
        send_frame(2001, 2000, 0);
        settle();
        exp_errs++;
        check_eq("early_errp", errp_cnt - err0, 1);
        check_eq("early_errcnt", 32'(err_count), exp_errs);
        check_eq("early_done", done_cnt - done0, 0);
        check_eq("early_writes", wr_cnt - wr0, BINS_KEPT);
        check_bram("early_bram");
        check_eq("early_hold_mag", 32'(peak_mag), last_mag);

        // Clean frame with enable dropped mid-frame.
        fill_rand();
        fork
            clean_frame("f7", 0);
            begin
                repeat (500) @(negedge clk);
                enable = 1'b0;
                repeat (100) @(negedge clk);
                enable = 1'b1;
            end
        join

        // Missing tlast at 4095; trailing beats end with tlast.
        fill_rand();
        snap();
        send_frame(FRAME_LEN, -1, 0);
        for (int i = 1; i <= 4; i++) drive_beat(24'h1, i, (i == 4), 0);
        settle();
        exp_errs++;
        check_eq("miss_errp", errp_cnt - err0, 1);
        check_eq("miss_errcnt", 32'(err_count), exp_errs);
        check_eq("miss_done", done_cnt - done0, 0);
        check_eq("miss_hold_idx", 32'(peak_index), last_idx);
        check_eq("miss_hold_mag", 32'(peak_mag), last_mag);

        // Index skip without tlast goes to DROP; tuser==0 there restarts a frame.
        snap();
        for (int i = 0; i < 10; i++) drive_beat(24'h77, i, 1'b0, 0);
        drive_beat(24'h77, 700, 1'b0, 0);
        drive_beat(24'h77, 5, 1'b0, 0);
        settle();
        exp_errs++;
        check_eq("skip_errp", errp_cnt - err0, 1);
        fill_rand();
        clean_frame("f9", 30);

        // Index mismatch on a tlast beat: one error, no report.
        fill_rand();
        snap();
        send_frame(3000, -1, 0);
        drive_beat(24'h9, 3001, 1'b1, 0);
        settle();
        exp_errs++;
        check_eq("mmlast_errp", errp_cnt - err0, 1);
        check_eq("mmlast_errcnt", 32'(err_count), exp_errs);
        check_eq("mmlast_done", done_cnt - done0, 0);

        // Asynchronous reset at beat 1500.
        fill_rand();
        snap();
        send_frame(1501, -1, 0);
        #1 rst_n = 1'b0;
        #1;
        exp_errs = 0;
        check_eq("amid_wr_en", 32'(wr_en), 0);
        check_eq("amid_pidx", 32'(peak_index), 0);
        check_eq("amid_pmag", 32'(peak_mag), 0);
        check_eq("amid_errcnt", 32'(err_count), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle();
        check_eq("amid_done", done_cnt - done0, 0);

        fill_rand();
        clean_frame("f12", 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
